// File: rtl/interrupt_controller_pkg.sv
// Shared I/O map and state encodings for the interrupt controller.
// The mask and flag registers live next to SREG/SPL/SPH in the I/O space.
package interrupt_controller_pkg;

    localparam logic [15:0] IO_SPL_ADDR  = 16'h003D;
    localparam logic [15:0] IO_SPH_ADDR  = 16'h003E;
    localparam logic [15:0] IO_SREG_ADDR = 16'h003F;
    localparam logic [15:0] IC_MSK_ADDR  = 16'h003A;
    localparam logic [15:0] IC_FLG_ADDR  = 16'h003B;

    typedef enum logic [1:0] {
        IC_STATE_IDLE = 2'd0,
        IC_STATE_REQ  = 2'd1,
        IC_STATE_HOLD = 2'd2
    } ic_state_e;

    function automatic int ic_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Lowest-index-wins priority encoder; purely combinational.
module priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx = '0;
        // Scanning downwards lets the lowest set bit overwrite any higher one.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detecting, maskable interrupt controller presenting one prioritised
// request (irq, vector) to the control unit, with mask/flag registers on the I/O bus.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int                    N_IRQ        = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    I_ADDR_WIDTH = 10,
    parameter logic [ADDR_WIDTH-1:0] MSK_ADDR     = ADDR_WIDTH'(IC_MSK_ADDR),
    parameter logic [ADDR_WIDTH-1:0] FLG_ADDR     = ADDR_WIDTH'(IC_FLG_ADDR)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IRQ-1:0]        irq_lines,
    input  logic                    global_ie,
    input  logic                    int_ack,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    inout  wire  [DATA_WIDTH-1:0]   bus_data,
    input  logic                    io_cs,
    input  logic                    io_we,
    input  logic                    io_oe
);

    localparam int SEL_W = ic_sel_width(N_IRQ);

    ic_state_e               state_q, state_d;
    logic [N_IRQ-1:0]        prev_q, prev_d;
    logic [N_IRQ-1:0]        pend_q, pend_d;
    logic [N_IRQ-1:0]        mask_q, mask_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    irq_q, irq_d;
    logic [I_ADDR_WIDTH-1:0] vector_q, vector_d;

    logic [N_IRQ-1:0]        rise;
    logic [N_IRQ-1:0]        act;
    logic [N_IRQ-1:0]        w1c;
    logic [N_IRQ-1:0]        ack_clr;
    logic [SEL_W-1:0]        enc_idx;
    logic                    enc_valid;
    logic                    hit_msk, hit_flg;
    logic                    wr_msk, wr_flg, rd_en;
    logic [DATA_WIDTH-1:0]   rd_data;

    assign rise = irq_lines & ~prev_q;
    assign act  = pend_q & mask_q;

    assign hit_msk = (bus_addr == MSK_ADDR);
    assign hit_flg = (bus_addr == FLG_ADDR);
    assign wr_msk  = io_cs & io_we & hit_msk;
    assign wr_flg  = io_cs & io_we & hit_flg;
    assign rd_en   = io_cs & io_oe & (hit_msk | hit_flg);
    assign w1c     = wr_flg ? bus_data[N_IRQ-1:0] : '0;

    priority_encoder #(
        .N     (N_IRQ),
        .IDX_W (SEL_W)
    ) u_prio (
        .req   (act),
        .idx   (enc_idx),
        .valid (enc_valid)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d = state_q;
        sel_d   = sel_q;
        ack_clr = '0;
        unique case (state_q)
            IC_STATE_IDLE: begin
                if (global_ie && enc_valid) begin
                    sel_d   = enc_idx;
                    state_d = IC_STATE_REQ;
                end
            end
            IC_STATE_REQ: begin
                if (int_ack) begin
                    ack_clr[sel_q] = 1'b1;
                    state_d        = IC_STATE_HOLD;
                end else if (!global_ie || !act[sel_q]) begin
                    state_d = IC_STATE_IDLE;
                end
            end
            IC_STATE_HOLD: state_d = IC_STATE_IDLE;
            default:       state_d = IC_STATE_IDLE;
        endcase
    end

    always_comb begin
        prev_d   = irq_lines;
        mask_d   = wr_msk ? bus_data[N_IRQ-1:0] : mask_q;
        // A new edge outranks an ack or W1C clear landing in the same cycle.
        pend_d   = (pend_q & ~(w1c | ack_clr)) | rise;
        irq_d    = (state_d == IC_STATE_REQ);
        vector_d = I_ADDR_WIDTH'(sel_d) + I_ADDR_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state_q  <= IC_STATE_IDLE;
            prev_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            sel_q    <= '0;
            irq_q    <= 1'b0;
            vector_q <= I_ADDR_WIDTH'(1);
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            sel_q    <= sel_d;
            irq_q    <= irq_d;
            vector_q <= vector_d;
        end
    end

    assign irq    = irq_q;
    assign vector = vector_q;

    always_comb begin
        rd_data = '0;
        if (hit_flg) begin
            rd_data[N_IRQ-1:0] = pend_q;
        end else begin
            rd_data[N_IRQ-1:0] = mask_q;
        end
    end

    assign bus_data = rd_en ? rd_data : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_interrupt_controller.sv
// Scoreboard bench for interrupt_controller: expectations are queued as stimulus
// is driven and compared against irq, vector and bus_data as they are produced.
module tb_interrupt_controller;

    localparam logic [15:0] MSK = 16'h003A;
    localparam logic [15:0] FLG = 16'h003B;
    localparam logic [15:0] OTHER = 16'h003C;
    localparam logic [7:0]  FLOAT = 8'hFF;

    typedef enum int {SRC_IRQ, SRC_VEC, SRC_BUS} src_e;
    typedef struct {
        string       tag;
        src_e        src;
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_lines;
    logic        global_ie;
    logic        int_ack;
    logic        irq;
    logic [9:0]  vector;
    logic [15:0] bus_addr;
    tri1  [7:0]  bus_data;
    logic        io_cs, io_we, io_oe;
    logic        tb_drive;
    logic [7:0]  tb_wdata;

    sb_entry_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    assign bus_data = tb_drive ? tb_wdata : 8'bzzzzzzzz;

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk       (clk),
        .reset     (reset),
        .irq_lines (irq_lines),
        .global_ie (global_ie),
        .int_ack   (int_ack),
        .irq       (irq),
        .vector    (vector),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .io_cs     (io_cs),
        .io_we     (io_we),
        .io_oe     (io_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input src_e src, input logic [31:0] exp);
        sb_entry_t e;
        e.tag = tag;
        e.src = src;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        sb_entry_t   e;
        logic [31:0] got;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.src)
                SRC_IRQ: got = {31'd0, irq};
                SRC_VEC: got = {22'd0, vector};
                default: got = {24'd0, bus_data};
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag, input logic e_irq, input logic [9:0] e_vec);
        push({tag, "_irq"}, SRC_IRQ, {31'd0, e_irq});
        push({tag, "_vec"}, SRC_VEC, {22'd0, e_vec});
        step();
        drain();
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        io_cs    = 1'b1;
        io_we    = 1'b1;
        bus_addr = a;
        tb_wdata = d;
        tb_drive = 1'b1;
        step();
        io_cs    = 1'b0;
        io_we    = 1'b0;
        tb_drive = 1'b0;
    endtask

    task automatic read_bus(input string tag, input logic [15:0] a, input logic oe,
                            input logic [7:0] exp);
        push(tag, SRC_BUS, {24'd0, exp});
        io_cs    = 1'b1;
        io_oe    = oe;
        bus_addr = a;
        #1;
        drain();
        io_cs = 1'b0;
        io_oe = 1'b0;
    endtask

    task automatic cleanup();
        global_ie = 1'b0;
        irq_lines = 8'h00;
        int_ack   = 1'b0;
        bus_write(FLG, 8'hFF);
        bus_write(MSK, 8'h00);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, expected summary before limit");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        irq_lines = 8'h00;
        global_ie = 1'b0;
        int_ack   = 1'b0;
        bus_addr  = 16'h0000;
        io_cs     = 1'b0;
        io_we     = 1'b0;
        io_oe     = 1'b0;
        tb_drive  = 1'b0;
        tb_wdata  = 8'h00;
        step();
        step();

        push("rst_irq", SRC_IRQ, 32'd0);
        push("rst_vec", SRC_VEC, 32'd1);
        drain();
        read_bus("rst_flg", FLG, 1'b1, 8'h00);
        read_bus("rst_msk", MSK, 1'b1, 8'h00);
        reset = 1'b1;
        step();

        // Single edge on line 0, acknowledged.
        bus_write(MSK, 8'h01);
        global_ie = 1'b1;
        irq_lines = 8'h01;
        step_chk("t1_pend", 1'b0, 10'd1);
        step_chk("t1_req", 1'b1, 10'd1);
        irq_lines = 8'h00;
        int_ack   = 1'b1;
        step_chk("t1_hold", 1'b0, 10'd1);
        int_ack   = 1'b0;
        read_bus("t1_flg", FLG, 1'b1, 8'h00);
        step_chk("t1_idle", 1'b0, 10'd1);
        step_chk("t1_no_rereq", 1'b0, 10'd1);
        cleanup();

        // Priority and freeze of sel during REQ.
        bus_write(MSK, 8'hFF);
        global_ie = 1'b1;
        irq_lines = 8'h24;
        step_chk("t2_pend", 1'b0, 10'd1);
        step_chk("t2_req", 1'b1, 10'd3);
        irq_lines = 8'h25;
        step_chk("t2_freeze1", 1'b1, 10'd3);
        step_chk("t2_freeze2", 1'b1, 10'd3);
        int_ack = 1'b1;
        step_chk("t2_hold", 1'b0, 10'd3);
        int_ack = 1'b0;
        read_bus("t2_flg", FLG, 1'b1, 8'h21);
        step_chk("t2_idle", 1'b0, 10'd3);
        step_chk("t2_rereq", 1'b1, 10'd1);
        cleanup();

        // Mask and global_ie gating.
        global_ie = 1'b1;
        irq_lines = 8'h08;
        step_chk("t3_pend", 1'b0, 10'd1);
        step_chk("t3_masked", 1'b0, 10'd1);
        irq_lines = 8'h00;
        read_bus("t3_flg_masked", FLG, 1'b1, 8'h08);
        push("t3_mskwr_irq", SRC_IRQ, 32'd0);
        bus_write(MSK, 8'h08);
        drain();
        step_chk("t3_unmasked", 1'b1, 10'd4);
        global_ie = 1'b0;
        step_chk("t3_ie_drop", 1'b0, 10'd4);
        read_bus("t3_flg_kept", FLG, 1'b1, 8'h08);
        cleanup();

        // Edge vs clear collisions.
        bus_write(MSK, 8'hFF);
        irq_lines = 8'h10;
        bus_write(FLG, 8'h10);
        read_bus("t4_set_wins", FLG, 1'b1, 8'h10);
        bus_write(FLG, 8'h00);
        read_bus("t4_w1c_zero", FLG, 1'b1, 8'h10);
        bus_write(OTHER, 8'hFF);
        read_bus("t4_other_flg", FLG, 1'b1, 8'h10);
        read_bus("t4_other_msk", MSK, 1'b1, 8'hFF);
        irq_lines = 8'h00;
        step();
        global_ie = 1'b1;
        step_chk("t4_req", 1'b1, 10'd5);
        int_ack   = 1'b1;
        irq_lines = 8'h10;
        step_chk("t4_ack_collide", 1'b0, 10'd5);
        int_ack   = 1'b0;
        read_bus("t4_flg_kept", FLG, 1'b1, 8'h10);
        step_chk("t4_idle", 1'b0, 10'd5);
        step_chk("t4_rereq", 1'b1, 10'd5);
        cleanup();

        // Bus read path and float when not selected.
        bus_write(MSK, 8'hA5);
        read_bus("t5_msk", MSK, 1'b1, 8'hA5);
        read_bus("t5_other_z", OTHER, 1'b1, FLOAT);
        read_bus("t5_no_oe_z", MSK, 1'b0, FLOAT);
        cleanup();

        // Reset in the middle of a request.
        bus_write(MSK, 8'h04);
        global_ie = 1'b1;
        irq_lines = 8'h04;
        step();
        step_chk("t6_req", 1'b1, 10'd3);
        reset = 1'b0;
        step_chk("t6_rst", 1'b0, 10'd1);
        read_bus("t6_flg", FLG, 1'b1, 8'h00);
        read_bus("t6_msk", MSK, 1'b1, 8'h00);
        irq_lines = 8'h00;
        reset     = 1'b1;
        step();
        step_chk("t6_after", 1'b0, 10'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
